// File: rtl/awg_pkg.sv
// Shared encodings for the AWG front-panel controller: edited-field select,
// one-hot waveform codes and the amplitude ceiling.
package awg_pkg;

    typedef enum logic [1:0] {
        SEL_FREQ  = 2'd0,
        SEL_AMP   = 2'd1,
        SEL_PHASE = 2'd2,
        SEL_RSVD  = 2'd3
    } sel_e;

    localparam logic [4:0] WAVE_SINE   = 5'b00001;
    localparam logic [4:0] WAVE_SQUARE = 5'b00010;
    localparam logic [4:0] WAVE_TRI    = 5'b00100;
    localparam logic [4:0] WAVE_SAW    = 5'b01000;
    localparam logic [4:0] WAVE_DC     = 5'b10000;

    localparam logic [2:0] AMP_MAX = 3'd7;

    function automatic logic [4:0] wave_next(input logic [4:0] w);
        return {w[3:0], w[4]};
    endfunction

endpackage

// File: rtl/awg_param_ctrl_key_debounce.sv
// One push-button: 2-flop synchronizer, level debounce, registered press pulse
// and optional hold-to-repeat pulse train.
module key_debounce #(
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter bit          ENABLE_REPEAT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o,
    output logic repeat_o
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_END    = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          vld1_q, vld2_q;
    logic          armed_q, armed_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q;
    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic          sample;

    // A key held through reset stays ignored until a real post-reset release is seen.
    assign sample = sync2_q & armed_q;

    always_comb begin
        armed_d = armed_q | (vld2_q & ~sync2_q);
        level_d = level_q;
        cnt_d   = '0;
        if (sample != level_q) begin
            if (cnt_q == DEB_LAST) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        hold_d = '0;
        rep_d  = 1'b0;
        if (ENABLE_REPEAT && level_q) begin
            if (hold_q == HOLD_END) begin
                hold_d = HOLD_RELOAD;
                rep_d  = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            hold_q      <= '0;
            rep_q       <= 1'b0;
        end else begin
            sync1_q     <= ~key_n_i;
            sync2_q     <= sync1_q;
            vld1_q      <= 1'b1;
            vld2_q      <= vld1_q;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
        end
    end

    assign press_o  = press_q;
    assign repeat_o = rep_q;

endmodule

// File: rtl/awg_param_ctrl.sv
// Front-panel controller for sig_gen: four debounced keys drive the edit FSM,
// saturating/wrapping field arithmetic, waveform rotation and an update strobe.
module awg_param_ctrl
    import awg_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned FREQ_STEP     = 10,
    parameter int unsigned FREQ_MIN      = 1,
    parameter int unsigned FREQ_MAX      = 4000,
    parameter int unsigned FREQ_RST      = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_mode,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_wave,
    output logic [4:0]  state,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic [1:0]  sel,
    output logic        cfg_update
);

    logic mode_press, mode_rep, up_press, up_rep;
    logic dn_press, dn_rep, wave_press, wave_rep;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
                   .REPEAT_CYCLES(REPEAT_CYCLES), .ENABLE_REPEAT(1'b0))
    u_key_mode (.clk_i(clk), .rst_i(rst), .key_n_i(key_mode),
                .press_o(mode_press), .repeat_o(mode_rep));

    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
                   .REPEAT_CYCLES(REPEAT_CYCLES), .ENABLE_REPEAT(1'b1))
    u_key_up (.clk_i(clk), .rst_i(rst), .key_n_i(key_up),
              .press_o(up_press), .repeat_o(up_rep));

    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
                   .REPEAT_CYCLES(REPEAT_CYCLES), .ENABLE_REPEAT(1'b1))
    u_key_down (.clk_i(clk), .rst_i(rst), .key_n_i(key_down),
                .press_o(dn_press), .repeat_o(dn_rep));

    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
                   .REPEAT_CYCLES(REPEAT_CYCLES), .ENABLE_REPEAT(1'b0))
    u_key_wave (.clk_i(clk), .rst_i(rst), .key_n_i(key_wave),
                .press_o(wave_press), .repeat_o(wave_rep));

    sel_e        sel_q, sel_d;
    logic [4:0]  wave_q, wave_d;
    logic [11:0] freq_q, freq_d;
    logic [2:0]  amp_q, amp_d;
    logic [7:0]  phase_q, phase_d;
    logic        upd_q, upd_d;

    logic        mode_ev, up_ev, dn_ev, wave_ev, step_up, step_dn;
    logic [12:0] f_wide, f_up, f_dn;

    assign mode_ev = mode_press | mode_rep;
    assign wave_ev = wave_press | wave_rep;
    assign up_ev   = up_press | up_rep;
    assign dn_ev   = dn_press | dn_rep;
    assign step_up = up_ev & ~dn_ev;
    assign step_dn = dn_ev & ~up_ev;

    // 13-bit headroom so the up-step can exceed FREQ_MAX and the down-step cannot wrap.
    always_comb begin
        f_wide = {1'b0, freq_q};
        f_up   = f_wide + 13'(FREQ_STEP);
        if (f_up > 13'(FREQ_MAX)) f_up = 13'(FREQ_MAX);
        if (f_wide < 13'(FREQ_STEP + FREQ_MIN)) f_dn = 13'(FREQ_MIN);
        else                                    f_dn = f_wide - 13'(FREQ_STEP);
    end

    always_comb begin
        sel_d   = sel_q;
        wave_d  = wave_q;
        freq_d  = freq_q;
        amp_d   = amp_q;
        phase_d = phase_q;

        case (sel_q)
            SEL_FREQ: begin
                if (step_up) freq_d = f_up[11:0];
                if (step_dn) freq_d = f_dn[11:0];
            end
            SEL_AMP: begin
                if (step_up && amp_q != AMP_MAX) amp_d = amp_q + 3'd1;
                if (step_dn && amp_q != 3'd0)    amp_d = amp_q - 3'd1;
            end
            SEL_PHASE: begin
                if (step_up) phase_d = phase_q + 8'd1;
                if (step_dn) phase_d = phase_q - 8'd1;
            end
            default: ;
        endcase

        if (mode_ev) begin
            case (sel_q)
                SEL_FREQ: sel_d = SEL_AMP;
                SEL_AMP:  sel_d = SEL_PHASE;
                default:  sel_d = SEL_FREQ;
            endcase
        end else if (sel_q == SEL_RSVD) begin
            sel_d = SEL_FREQ;
        end

        if (wave_ev) wave_d = wave_next(wave_q);

        upd_d = (wave_d != wave_q) | (freq_d != freq_q) |
                (amp_d != amp_q) | (phase_d != phase_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= SEL_FREQ;
            wave_q  <= WAVE_SINE;
            freq_q  <= 12'(FREQ_RST);
            amp_q   <= AMP_MAX;
            phase_q <= 8'd0;
            upd_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            wave_q  <= wave_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            phase_q <= phase_d;
            upd_q   <= upd_d;
        end
    end

    assign state       = wave_q;
    assign state_freq  = freq_q;
    assign state_amp   = amp_q;
    assign state_phase = phase_q;
    assign sel         = sel_q;
    assign cfg_update  = upd_q;

endmodule
